// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard port: receiver states,
// status-word bit positions and the bus address of the keyboard port.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int XK_READY   = 15;
   localparam int XK_OVF     = 14;
   localparam int XK_ERR     = 13;
   localparam int XK_CNT_LSB = 8;

   localparam logic [31:0] PS2_ADDR = 32'h0000_0600;

   // True when the eight data bits plus the parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises and filters the pins, detects falling
// clock edges and assembles start/8 data/parity/stop frames into bytes.
// A watchdog abandons frames whose clock stalls mid-frame.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_vld,
   output logic       err
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]            clk_sync;
   logic [1:0]            data_sync;
   logic [FILTER_LEN-1:0] hist;
   logic [FILTER_LEN-1:0] hist_next;
   logic                  filt;
   logic                  filt_q;
   logic                  fall;
   logic                  din;

   rx_state_t             state, state_n;
   logic [2:0]            bit_cnt, bit_cnt_n;
   logic [7:0]            shreg, shreg_n;
   logic                  par_bit, par_bit_n;
   logic [WD_W-1:0]       wdog, wdog_n;
   logic [7:0]            rx_byte_n;
   logic                  byte_vld_n;
   logic                  err_n;

   assign hist_next = {hist[FILTER_LEN-2:0], clk_sync[1]};
   assign fall      = filt_q & ~filt;
   assign din       = data_sync[1];

   // Pin synchronisers and the run filter that debounces the PS/2 clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync  <= '0;
         data_sync <= '0;
         hist      <= '0;
         filt      <= 1'b0;
         filt_q    <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         hist      <= hist_next;
         if (&hist_next)
            filt <= 1'b1;
         else if (~|hist_next)
            filt <= 1'b0;
         filt_q    <= filt;
      end
   end

   // Receiver state, shift register, watchdog and registered result pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         wdog     <= '0;
         rx_byte  <= '0;
         byte_vld <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         par_bit  <= par_bit_n;
         wdog     <= wdog_n;
         rx_byte  <= rx_byte_n;
         byte_vld <= byte_vld_n;
         err      <= err_n;
      end
   end

   // Frame decoding, advanced once per filtered clock falling edge, plus stall timeout.
   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      par_bit_n  = par_bit;
      rx_byte_n  = rx_byte;
      byte_vld_n = 1'b0;
      err_n      = 1'b0;
      wdog_n     = (state == IDLE || fall) ? '0 : wdog + 1'b1;

      case (state)
         IDLE: begin
            if (fall && !din) begin
               state_n   = DATA;
               bit_cnt_n = '0;
            end
         end
         DATA: begin
            if (fall) begin
               shreg_n   = {din, shreg[7:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7)
                  state_n = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_bit_n = din;
               state_n   = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_n = IDLE;
               if (din && odd_parity_ok(shreg, par_bit)) begin
                  rx_byte_n  = shreg;
                  byte_vld_n = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (state != IDLE && !fall && wdog == WD_W'(TIMEOUT_CYC - 1)) begin
         state_n = IDLE;
         err_n   = 1'b1;
         wdog_n  = '0;
      end
   end

endmodule

// File: rtl/ps2_key_port.sv
// Keyboard bus responder: buffers received scan codes in a small FIFO and
// presents head byte plus status on xkey; each rising edge of rd pops one entry
// and clears the sticky error flags.
module ps2_key_port
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 100000,
   parameter int FIFO_AW     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        rd,
   output logic [15:0] xkey,
   output logic        key_irq
);

   localparam int                DEPTH    = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);

   logic [7:0]         rx_byte;
   logic               byte_vld;
   logic               rx_err;

   logic               rd_q;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic [FIFO_AW:0]   count_n;
   logic               ovf;
   logic               ferr;

   logic               pop;
   logic               empty;
   logic               full;
   logic               do_pop;
   logic               do_push;
   logic               drop;

   ps2_rx_frame #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .byte_vld (byte_vld),
      .err      (rx_err)
   );

   assign pop     = rd & ~rd_q;
   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = byte_vld & (~full | do_pop);
   assign drop    = byte_vld & full & ~do_pop;

   // Next occupancy from the push/pop combination of this cycle.
   always_comb begin
      count_n = count;
      if (do_push && !do_pop)
         count_n = count + 1'b1;
      else if (!do_push && do_pop)
         count_n = count - 1'b1;
   end

   // FIFO pointers, count, read-edge detector and sticky flags (set beats clear).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q    <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         ferr    <= 1'b0;
         key_irq <= 1'b0;
      end else begin
         rd_q    <= rd;
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count   <= count_n;
         ovf     <= drop | (ovf & ~pop);
         ferr    <= rx_err | (ferr & ~pop);
         key_irq <= (count_n != '0);
      end
   end

   // FIFO storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= rx_byte;
   end

   // Status word assembled from registered state and the FIFO head.
   always_comb begin
      xkey                     = '0;
      xkey[XK_READY]           = ~empty;
      xkey[XK_OVF]             = ovf;
      xkey[XK_ERR]             = ferr;
      xkey[XK_CNT_LSB +: 4]    = 4'(count);
      xkey[7:0]                = empty ? 8'h00 : mem[rd_ptr];
   end

endmodule

// File: tb/tb_ps2_key_port.sv
// Testbench for ps2_key_port: drives PS/2 frames on the pins and bus reads,
// comparing xkey/key_irq with a queue-based model of the keyboard port.
module tb_ps2_key_port;

   localparam int HALF    = 12;
   localparam int TIMEOUT = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        rd = 1'b0;
   logic [15:0] xkey;
   logic        key_irq;

   int          vectors = 0;
   int          miscompares = 0;

   logic [7:0]  model_q[$];
   bit          model_ovf = 1'b0;
   bit          model_err = 1'b0;

   ps2_key_port #(
      .FILTER_LEN  (4),
      .TIMEOUT_CYC (TIMEOUT),
      .FIFO_AW     (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rd       (rd),
      .xkey     (xkey),
      .key_irq  (key_irq)
   );

   // 100 MHz system clock.
   always #5 clk = ~clk;

   function automatic logic [15:0] model_xkey();
      logic [15:0] v;
      v = '0;
      v[15]   = (model_q.size() != 0);
      v[14]   = model_ovf;
      v[13]   = model_err;
      v[11:8] = 4'(model_q.size());
      if (model_q.size() != 0)
         v[7:0] = model_q[0];
      return v;
   endfunction

   function automatic void model_frame(input logic [7:0] b, input bit good);
      if (!good)
         model_err = 1'b1;
      else if (model_q.size() >= 8)
         model_ovf = 1'b1;
      else
         model_q.push_back(b);
   endfunction

   function automatic void model_read();
      if (model_q.size() != 0)
         void'(model_q.pop_front());
      model_ovf = 1'b0;
      model_err = 1'b0;
   endfunction

   function automatic void model_reset();
      model_q.delete();
      model_ovf = 1'b0;
      model_err = 1'b0;
   endfunction

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_head(input logic [7:0] b, input logic bad_par);
      logic par;
      par = (~^b) ^ bad_par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++)
         ps2_bit(b[i]);
      ps2_bit(par);
   endtask

   task automatic send_stop();
      ps2_bit(1'b1);
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      send_head(b, bad_par);
      send_stop();
   endtask

   task automatic do_read(input int hold);
      @(negedge clk);
      rd = 1'b1;
      repeat (hold) @(negedge clk);
      rd = 1'b0;
      repeat (2) @(negedge clk);
      model_read();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         ps2_clk  = 1'($urandom);
         ps2_data = 1'($urandom);
         rd       = 1'($urandom);
      end
      vectors++;
      if (xkey !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL reset_xkey: got %h want %h", xkey, 16'h0000);
      end
      vectors++;
      if (key_irq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_irq: got %b want 0", key_irq);
      end
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rd       = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (10) @(negedge clk);
      vectors++;
      if (xkey !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL post_reset_xkey: got %h want %h", xkey, 16'h0000);
      end
      vectors++;
      if (key_irq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL post_reset_irq: got %b want 0", key_irq);
      end
   endtask

   task automatic test_single_frame();
      send_head(8'h1C, 1'b0);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      // Pin fall -> 2 sync stages + 4 filter samples -> fall strobe -> byte pulse -> push.
      repeat (7) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (xkey !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL pre_push: got %h want %h", xkey, 16'h0000);
      end
      @(negedge clk);
      vectors++;
      if (xkey !== 16'h811C) begin
         miscompares++;
         $display("[TB] FAIL stop_to_ready: got %h want %h", xkey, 16'h811C);
      end
      vectors++;
      if (key_irq !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL single_irq: got %b want 1", key_irq);
      end
      repeat (HALF - 2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
      model_frame(8'h1C, 1'b1);
      do_read(5);
      vectors++;
      if (xkey !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL single_pop: got %h want %h", xkey, 16'h0000);
      end
      vectors++;
      if (key_irq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL single_irq_clear: got %b want 0", key_irq);
      end
   endtask

   task automatic test_burst_overflow();
      for (int i = 1; i <= 9; i++) begin
         send_frame(8'(i), 1'b0);
         model_frame(8'(i), 1'b1);
      end
      vectors++;
      if (xkey !== 16'hC801) begin
         miscompares++;
         $display("[TB] FAIL burst_full: got %h want %h", xkey, 16'hC801);
      end
      for (int k = 0; k < 8; k++) begin
         do_read(1 + int'($urandom_range(0, 4)));
         vectors++;
         if (xkey !== model_xkey()) begin
            miscompares++;
            $display("[TB] FAIL burst_read%0d: got %h want %h", k, xkey, model_xkey());
         end
         if (k == 0) begin
            vectors++;
            if (xkey !== 16'h8702) begin
               miscompares++;
               $display("[TB] FAIL burst_ovf_clear: got %h want %h", xkey, 16'h8702);
            end
         end
      end
   endtask

   task automatic test_bad_parity();
      send_frame(8'h1C, 1'b1);
      model_frame(8'h1C, 1'b0);
      vectors++;
      if (xkey !== 16'h2000) begin
         miscompares++;
         $display("[TB] FAIL bad_parity: got %h want %h", xkey, 16'h2000);
      end
      do_read(2);
      vectors++;
      if (xkey !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL parity_clear: got %h want %h", xkey, 16'h0000);
      end
   endtask

   task automatic test_timeout();
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++)
         ps2_bit(1'($urandom));
      repeat (TIMEOUT + 100) @(negedge clk);
      model_err = 1'b1;
      vectors++;
      if (xkey !== 16'h2000) begin
         miscompares++;
         $display("[TB] FAIL timeout_err: got %h want %h", xkey, 16'h2000);
      end
      send_frame(8'hF0, 1'b0);
      model_frame(8'hF0, 1'b1);
      vectors++;
      if (xkey !== 16'hA1F0) begin
         miscompares++;
         $display("[TB] FAIL timeout_recover: got %h want %h", xkey, 16'hA1F0);
      end
      do_read(1);
   endtask

   task automatic test_full_coincident();
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b0);
         model_frame(b, 1'b1);
      end
      vectors++;
      if (xkey !== model_xkey()) begin
         miscompares++;
         $display("[TB] FAIL fill8: got %h want %h", xkey, model_xkey());
      end
      send_head(8'h55, 1'b0);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      repeat (HALF - 2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
      model_read();
      model_frame(8'h55, 1'b1);
      vectors++;
      if (xkey !== model_xkey()) begin
         miscompares++;
         $display("[TB] FAIL coincident: got %h want %h", xkey, model_xkey());
      end
      vectors++;
      if (xkey[14:8] !== 7'h08) begin
         miscompares++;
         $display("[TB] FAIL coincident_cnt: got %h want %h", xkey[14:8], 7'h08);
      end
      for (int k = 0; k < 8; k++) begin
         do_read(1);
         vectors++;
         if (xkey !== model_xkey()) begin
            miscompares++;
            $display("[TB] FAIL drain%0d: got %h want %h", k, xkey, model_xkey());
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++)
         ps2_bit(1'b1);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (xkey !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL midframe_reset: got %h want %h", xkey, 16'h0000);
      end
      rst = 1'b1;
      model_reset();
      repeat (10) @(negedge clk);
      send_frame(8'hA5, 1'b0);
      model_frame(8'hA5, 1'b1);
      vectors++;
      if (xkey !== 16'h81A5) begin
         miscompares++;
         $display("[TB] FAIL midframe_recover: got %h want %h", xkey, 16'h81A5);
      end
      do_read(1);
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         bad;
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 2) != 0) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send_frame(b, bad);
            model_frame(b, !bad);
         end else begin
            do_read(1 + int'($urandom_range(0, 5)));
         end
         vectors++;
         if (xkey !== model_xkey()) begin
            miscompares++;
            $display("[TB] FAIL random%0d: got %h want %h", it, xkey, model_xkey());
         end
         vectors++;
         if (key_irq !== (model_q.size() != 0)) begin
            miscompares++;
            $display("[TB] FAIL random_irq%0d: got %b want %b", it, key_irq, model_q.size() != 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_burst_overflow();
      test_bad_parity();
      test_timeout();
      test_full_coincident();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
